str_next_renderer: RTL and testbench

- Sequential pixel-stream reader for the 32-bit-wide "NEXT" string bitmap ROM: 4 glyphs of 64 rows each, row-major, glyph g at addresses g*64..g*64+63.
- Sits between the VGA timing generator and the pixel mixer. It takes the current raster coordinate, drives the ROM address, and returns a registered on/off pixel for a movable, optionally magnified and blinking "NEXT" label.

---
 rtl/str_next_renderer.sv | 154 +++++++++++++++
 tb/tb_str_next_renderer.sv | 197 +++++++++++++++++++
 2 files changed

// File: rtl/str_next_renderer.sv
// str_next_renderer: two-stage pixel reader for the "NEXT" label bitmap ROM.
// The raster coordinate is registered, turned into a ROM row address, and the
// returned ROM word is reduced to one registered on/off pixel. The label can be
// moved tear-free, magnified by a power of two, and blinked per frame.
//
// Stream semantics: pixel_v_i qualifies pixel_x_i/pixel_y_i in the same cycle.
// There is no back-pressure. The pipeline advances every cycle, and pixel_v_o is
// pixel_v_i delayed by exactly two cycles, aligned with pixel_o and in_region_o.
module str_next_renderer #(
  parameter int width_p        = 32,
  parameter int depth_p        = 256,
  parameter int glyphs_p       = 4,
  parameter int glyph_h_p      = 64,
  parameter int x_w_p          = 10,
  parameter int y_w_p          = 10,
  parameter int scale_lg_p     = 0,
  parameter int blink_frames_p = 30
) (
  input  logic                       clk_i,
  input  logic                       reset_n_i,
  input  logic [x_w_p-1:0]           origin_x_i,
  input  logic [y_w_p-1:0]           origin_y_i,
  input  logic                       origin_v_i,
  input  logic                       frame_start_i,
  input  logic                       blink_en_i,
  input  logic [x_w_p-1:0]           pixel_x_i,
  input  logic [y_w_p-1:0]           pixel_y_i,
  input  logic                       pixel_v_i,
  output logic [$clog2(depth_p)-1:0] rom_addr_o,
  input  logic [width_p-1:0]         rom_data_i,
  output logic                       pixel_v_o,
  output logic                       pixel_o,
  output logic                       in_region_o
);

  localparam int addr_w = $clog2(depth_p);
  localparam int col_w  = (width_p > 1) ? $clog2(width_p) : 1;
  localparam int cnt_w  = (blink_frames_p > 1) ? $clog2(blink_frames_p) : 1;
  localparam int unsigned box_w = (glyphs_p * width_p) << scale_lg_p;
  localparam int unsigned box_h = glyph_h_p << scale_lg_p;
  localparam logic [col_w-1:0] col_max  = col_w'(width_p - 1);
  localparam logic [cnt_w-1:0] cnt_last = cnt_w'(blink_frames_p - 1);

  // Active origin used for decode, plus a pending copy applied at frame start.
  logic [x_w_p-1:0] org_x, pend_x;
  logic [y_w_p-1:0] org_y, pend_y;
  logic             pend_v;

  // Blink state.
  logic [cnt_w-1:0] blink_cnt;
  logic             visible;

  // Stage-1 registers.
  logic [x_w_p-1:0] s1_x;
  logic [y_w_p-1:0] s1_y;
  logic             s1_v;

  // Stage-1 decode.
  logic [x_w_p:0]   rx;
  logic [y_w_p:0]   ry;
  logic [x_w_p-1:0] sx;
  logic [y_w_p-1:0] sy;
  logic [x_w_p-1:0] glyph;
  logic [col_w-1:0] col;
  logic             hit;
  logic             pix_bit;

  // Origin shadowing: a request made during the frame is held until frame start;
  // a request coinciding with frame start takes effect directly.
  always_ff @(posedge clk_i or negedge reset_n_i) begin
    if (!reset_n_i) begin
      org_x  <= '0;
      org_y  <= '0;
      pend_x <= '0;
      pend_y <= '0;
      pend_v <= 1'b0;
    end else if (origin_v_i && frame_start_i) begin
      org_x  <= origin_x_i;
      org_y  <= origin_y_i;
      pend_v <= 1'b0;
    end else if (origin_v_i) begin
      pend_x <= origin_x_i;
      pend_y <= origin_y_i;
      pend_v <= 1'b1;
    end else if (frame_start_i && pend_v) begin
      org_x  <= pend_x;
      org_y  <= pend_y;
      pend_v <= 1'b0;
    end
  end

  // Blink phase counter: toggles visibility every blink_frames_p frames while enabled.
  always_ff @(posedge clk_i or negedge reset_n_i) begin
    if (!reset_n_i) begin
      blink_cnt <= '0;
      visible   <= 1'b1;
    end else if (!blink_en_i) begin
      blink_cnt <= '0;
      visible   <= 1'b1;
    end else if (frame_start_i) begin
      if (blink_cnt == cnt_last) begin
        blink_cnt <= '0;
        visible   <= ~visible;
      end else begin
        blink_cnt <= blink_cnt + 1'b1;
      end
    end
  end

  // Stage 1: capture the raster coordinate.
  always_ff @(posedge clk_i or negedge reset_n_i) begin
    if (!reset_n_i) begin
      s1_x <= '0;
      s1_y <= '0;
      s1_v <= 1'b0;
    end else begin
      s1_x <= pixel_x_i;
      s1_y <= pixel_y_i;
      s1_v <= pixel_v_i;
    end
  end

  // Relative position, box test and ROM address; the top bit of rx/ry is the borrow.
  always_comb begin
    rx    = {1'b0, s1_x} - {1'b0, org_x};
    ry    = {1'b0, s1_y} - {1'b0, org_y};
    sx    = rx[x_w_p-1:0] >> scale_lg_p;
    sy    = ry[y_w_p-1:0] >> scale_lg_p;
    glyph = x_w_p'(sx / width_p);
    col   = col_w'(sx % width_p);
    hit   = s1_v && !rx[x_w_p] && !ry[y_w_p] &&
            (32'(rx[x_w_p-1:0]) < box_w) && (32'(ry[y_w_p-1:0]) < box_h);
    rom_addr_o = '0;
    if (hit) begin
      rom_addr_o = addr_w'(32'(glyph) * glyph_h_p + 32'(sy));
    end
    // Leftmost column is the ROM word MSB.
    pix_bit = rom_data_i[col_max - col];
  end

  // Stage 2: registered outputs; blink masks the pixel but not the region flag.
  always_ff @(posedge clk_i or negedge reset_n_i) begin
    if (!reset_n_i) begin
      pixel_o     <= 1'b0;
      in_region_o <= 1'b0;
      pixel_v_o   <= 1'b0;
    end else begin
      pixel_o     <= hit & pix_bit & visible;
      in_region_o <= hit;
      pixel_v_o   <= s1_v;
    end
  end

endmodule

// File: tb/tb_str_next_renderer.sv
// Directed bench for str_next_renderer: one instance at scale 1x with a short
// blink period, one at 2x magnification, both fed from a shared bench ROM.
module tb_str_next_renderer;

  logic       clk = 1'b0;
  logic       reset_n = 1'b0;
  logic [9:0] origin_x = '0, origin_y = '0;
  logic       origin_v = 1'b0, frame_start = 1'b0, blink_en = 1'b0;
  logic [9:0] pixel_x = '0, pixel_y = '0;
  logic       pixel_v = 1'b0;

  logic [7:0]  rom_addr0, rom_addr1;
  logic [31:0] rom_data0, rom_data1;
  logic        pv0, pix0, reg0, pv1, pix1, reg1;
  logic [31:0] mem [256];

  int n_cmp = 0;
  int n_fail = 0;

  assign rom_data0 = mem[rom_addr0];
  assign rom_data1 = mem[rom_addr1];

  str_next_renderer #(.blink_frames_p(2)) dut0 (
    .clk_i(clk), .reset_n_i(reset_n),
    .origin_x_i(origin_x), .origin_y_i(origin_y), .origin_v_i(origin_v),
    .frame_start_i(frame_start), .blink_en_i(blink_en),
    .pixel_x_i(pixel_x), .pixel_y_i(pixel_y), .pixel_v_i(pixel_v),
    .rom_addr_o(rom_addr0), .rom_data_i(rom_data0),
    .pixel_v_o(pv0), .pixel_o(pix0), .in_region_o(reg0)
  );

  str_next_renderer #(.scale_lg_p(1)) dut1 (
    .clk_i(clk), .reset_n_i(reset_n),
    .origin_x_i(origin_x), .origin_y_i(origin_y), .origin_v_i(origin_v),
    .frame_start_i(frame_start), .blink_en_i(blink_en),
    .pixel_x_i(pixel_x), .pixel_y_i(pixel_y), .pixel_v_i(pixel_v),
    .rom_addr_o(rom_addr1), .rom_data_i(rom_data1),
    .pixel_v_o(pv1), .pixel_o(pix1), .in_region_o(reg1)
  );

  // Clock.
  always #5 clk = ~clk;

  // Driver: present one valid pixel, capture the ROM address one edge later and
  // the registered outputs after the second edge.
  task automatic run_pixel(input bit sel, input logic [9:0] x, input logic [9:0] y,
                           output logic [7:0] addr, output logic pix,
                           output logic reg_o, output logic pv);
    @(negedge clk);
    pixel_x = x; pixel_y = y; pixel_v = 1'b1;
    @(posedge clk); #1;
    addr = sel ? rom_addr1 : rom_addr0;
    @(negedge clk);
    pixel_v = 1'b0;
    @(posedge clk); #1;
    pix   = sel ? pix1 : pix0;
    reg_o = sel ? reg1 : reg0;
    pv    = sel ? pv1 : pv0;
  endtask

  task automatic load_origin(input logic [9:0] x, input logic [9:0] y, input logic fs);
    @(negedge clk);
    origin_x = x; origin_y = y; origin_v = 1'b1; frame_start = fs;
    @(negedge clk);
    origin_v = 1'b0; frame_start = 1'b0;
  endtask

  task automatic pulse_frame();
    @(negedge clk);
    frame_start = 1'b1;
    @(negedge clk);
    frame_start = 1'b0;
  endtask

  task automatic test_reset();
    @(negedge clk);
    n_cmp++; if (rom_addr0 !== 8'd0) begin n_fail++; $display("FAIL reset_addr: got %0d want 0", rom_addr0); end
    n_cmp++; if ({pix0, reg0, pv0} !== 3'b000) begin n_fail++; $display("FAIL reset_outs: got %b want 000", {pix0, reg0, pv0}); end
    n_cmp++; if ({pix1, reg1, pv1} !== 3'b000) begin n_fail++; $display("FAIL reset_outs_x2: got %b want 000", {pix1, reg1, pv1}); end
    reset_n = 1'b1;
  endtask

  task automatic test_scaled();
    logic [7:0] a; logic p, r, v;
    run_pixel(1'b1, 10'd3, 10'd23, a, p, r, v);
    n_cmp++; if (a !== 8'd11) begin n_fail++; $display("FAIL x2_addr_3_23: got %0d want 11", a); end
    n_cmp++; if ({p, r, v} !== 3'b111) begin n_fail++; $display("FAIL x2_pix_3_23: got %b want 111", {p, r, v}); end
    run_pixel(1'b1, 10'd255, 10'd127, a, p, r, v);
    n_cmp++; if (a !== 8'd255) begin n_fail++; $display("FAIL x2_addr_255_127: got %0d want 255", a); end
    n_cmp++; if ({p, r} !== 2'b11) begin n_fail++; $display("FAIL x2_pix_255_127: got %b want 11", {p, r}); end
    run_pixel(1'b1, 10'd64, 10'd0, a, p, r, v);
    n_cmp++; if (a !== 8'd64) begin n_fail++; $display("FAIL x2_addr_64_0: got %0d want 64", a); end
    n_cmp++; if ({p, r} !== 2'b11) begin n_fail++; $display("FAIL x2_pix_64_0: got %b want 11", {p, r}); end
    run_pixel(1'b1, 10'd256, 10'd0, a, p, r, v);
    n_cmp++; if ({a, p, r} !== {8'd0, 2'b00}) begin n_fail++; $display("FAIL x2_edge_256_0: got %0d/%b want 0/00", a, {p, r}); end
    run_pixel(1'b1, 10'd0, 10'd128, a, p, r, v);
    n_cmp++; if ({a, p, r} !== {8'd0, 2'b00}) begin n_fail++; $display("FAIL x2_edge_0_128: got %0d/%b want 0/00", a, {p, r}); end
  endtask

  task automatic test_basic();
    logic [7:0] a; logic p, r, v;
    load_origin(10'd100, 10'd50, 1'b0);
    pulse_frame();
    run_pixel(1'b0, 10'd100, 10'd61, a, p, r, v);
    n_cmp++; if (a !== 8'd11) begin n_fail++; $display("FAIL addr_100_61: got %0d want 11", a); end
    n_cmp++; if ({p, r, v} !== 3'b011) begin n_fail++; $display("FAIL pix_100_61: got %b want 011", {p, r, v}); end
    run_pixel(1'b0, 10'd101, 10'd61, a, p, r, v);
    n_cmp++; if ({a, p, r} !== {8'd11, 2'b11}) begin n_fail++; $display("FAIL pix_101_61: got %0d/%b want 11/11", a, {p, r}); end
  endtask

  task automatic test_glyph_decode();
    logic [7:0] a; logic p, r, v;
    run_pixel(1'b0, 10'd132, 10'd50, a, p, r, v);
    n_cmp++; if ({a, p, r} !== {8'd64, 2'b11}) begin n_fail++; $display("FAIL glyph1_132_50: got %0d/%b want 64/11", a, {p, r}); end
    run_pixel(1'b0, 10'd227, 10'd113, a, p, r, v);
    n_cmp++; if ({a, p, r} !== {8'd255, 2'b11}) begin n_fail++; $display("FAIL last_227_113: got %0d/%b want 255/11", a, {p, r}); end
    run_pixel(1'b0, 10'd228, 10'd50, a, p, r, v);
    n_cmp++; if ({a, p, r} !== {8'd0, 2'b00}) begin n_fail++; $display("FAIL right_228_50: got %0d/%b want 0/00", a, {p, r}); end
    run_pixel(1'b0, 10'd99, 10'd50, a, p, r, v);
    n_cmp++; if ({a, p, r} !== {8'd0, 2'b00}) begin n_fail++; $display("FAIL left_99_50: got %0d/%b want 0/00", a, {p, r}); end
    run_pixel(1'b0, 10'd100, 10'd114, a, p, r, v);
    n_cmp++; if ({a, p, r} !== {8'd0, 2'b00}) begin n_fail++; $display("FAIL below_100_114: got %0d/%b want 0/00", a, {p, r}); end
  endtask

  task automatic test_shadow();
    logic [7:0] a; logic p, r, v;
    load_origin(10'd5, 10'd5, 1'b0);
    load_origin(10'd200, 10'd10, 1'b0);
    run_pixel(1'b0, 10'd132, 10'd50, a, p, r, v);
    n_cmp++; if ({a, r} !== {8'd64, 1'b1}) begin n_fail++; $display("FAIL shadow_hold: got %0d/%b want 64/1", a, r); end
    pulse_frame();
    run_pixel(1'b0, 10'd200, 10'd10, a, p, r, v);
    n_cmp++; if ({a, p, r} !== {8'd0, 2'b11}) begin n_fail++; $display("FAIL shadow_apply: got %0d/%b want 0/11", a, {p, r}); end
    run_pixel(1'b0, 10'd132, 10'd50, a, p, r, v);
    n_cmp++; if ({a, r} !== {8'd0, 1'b0}) begin n_fail++; $display("FAIL shadow_old_gone: got %0d/%b want 0/0", a, r); end
    pulse_frame();
    run_pixel(1'b0, 10'd232, 10'd10, a, p, r, v);
    n_cmp++; if ({a, r} !== {8'd64, 1'b1}) begin n_fail++; $display("FAIL shadow_no_pending: got %0d/%b want 64/1", a, r); end
    load_origin(10'd100, 10'd50, 1'b1);
    run_pixel(1'b0, 10'd132, 10'd50, a, p, r, v);
    n_cmp++; if ({a, r} !== {8'd64, 1'b1}) begin n_fail++; $display("FAIL shadow_simul: got %0d/%b want 64/1", a, r); end
  endtask

  task automatic test_blink();
    logic [7:0] a; logic p, r, v;
    logic exp_p [5] = '{1'b1, 1'b1, 1'b0, 1'b0, 1'b1};
    @(negedge clk);
    blink_en = 1'b1;
    for (int f = 0; f < 5; f++) begin
      run_pixel(1'b0, 10'd101, 10'd61, a, p, r, v);
      n_cmp++; if ({p, r} !== {exp_p[f], 1'b1}) begin n_fail++; $display("FAIL blink_frame%0d: got %b want %b1", f, {p, r}, exp_p[f]); end
      pulse_frame();
    end
    pulse_frame();
    run_pixel(1'b0, 10'd101, 10'd61, a, p, r, v);
    n_cmp++; if ({p, r} !== 2'b01) begin n_fail++; $display("FAIL blink_hidden: got %b want 01", {p, r}); end
    @(negedge clk);
    blink_en = 1'b0;
    run_pixel(1'b0, 10'd101, 10'd61, a, p, r, v);
    n_cmp++; if ({p, r} !== 2'b11) begin n_fail++; $display("FAIL blink_off: got %b want 11", {p, r}); end
  endtask

  task automatic test_async_reset();
    logic [7:0] a; logic p, r, v;
    @(negedge clk);
    pixel_x = 10'd101; pixel_y = 10'd61; pixel_v = 1'b1;
    repeat (2) @(posedge clk);
    #1;
    n_cmp++; if ({pix0, reg0, pv0} !== 3'b111) begin n_fail++; $display("FAIL pre_reset: got %b want 111", {pix0, reg0, pv0}); end
    #2 reset_n = 1'b0;
    #1;
    n_cmp++; if ({pix0, reg0, pv0} !== 3'b000) begin n_fail++; $display("FAIL async_reset: got %b want 000", {pix0, reg0, pv0}); end
    @(negedge clk);
    pixel_v = 1'b0;
    reset_n = 1'b1;
    run_pixel(1'b0, 10'd0, 10'd0, a, p, r, v);
    n_cmp++; if ({a, p, r, v} !== {8'd0, 3'b111}) begin n_fail++; $display("FAIL reset_origin: got %0d/%b want 0/111", a, {p, r, v}); end
  endtask

  initial begin
    for (int i = 0; i < 256; i++) mem[i] = 32'h0;
    mem[0]   = 32'hFFFF_FFFF;
    mem[11]  = 32'h7FC0_03FF;
    mem[64]  = 32'h8000_0000;
    mem[255] = 32'h0000_0001;
    test_reset();
    test_scaled();
    test_basic();
    test_glyph_decode();
    test_shadow();
    test_blink();
    test_async_reset();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

endmodule
